// File: rtl/primitive_batch_sequencer.sv
// Walks a leaf primitive range in batches of UNITS: drives the query index and bound to the
// primitive unit, captures its records after LATENCY cycles and offers them downstream.
module primitive_batch_sequencer #(
  parameter int unsigned IDX_W   = 16,
  parameter int unsigned UNITS   = 2,
  parameter int unsigned PRIM_W  = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [IDX_W-1:0]          req_start,
  input  logic [IDX_W-1:0]          req_count,
  input  logic                      flush,
  output logic [IDX_W-1:0]          prim_index,
  output logic [IDX_W-1:0]          prim_bound,
  input  logic [UNITS*PRIM_W-1:0]   prim_data,
  output logic                      bat_valid,
  input  logic                      bat_ready,
  output logic [UNITS*PRIM_W-1:0]   bat_data,
  output logic [UNITS-1:0]          bat_mask,
  output logic                      bat_last,
  output logic                      done
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [IDX_W:0] SAT_END = {2'b01, {(IDX_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             accept, empty, xfer, wait_end;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] bound_in;
  logic [UNITS-1:0] mask_c;
  logic             last_c;

  always_comb begin
    accept   = (state == IDLE) && req_valid && !flush;
    empty    = (req_count == '0) || req_start[IDX_W-1];
    xfer     = (state == HOLD) && bat_ready && !flush;
    wait_end = (state == WAIT) && (cnt == CNT_W'(1));
    sum      = {1'b0, req_start} + {1'b0, req_count};
    bound_in = (sum >= SAT_END) ? SAT_END[IDX_W-1:0] : sum[IDX_W-1:0];
  end

  // Lane qualification is evaluated one bit wider so index+lane never wraps near the saturated end.
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < UNITS; i++)
      mask_c[i] = ({1'b0, prim_index} + (IDX_W+1)'(i)) < {1'b0, prim_bound};
    last_c = ({1'b0, prim_index} + (IDX_W+1)'(UNITS)) >= {1'b0, prim_bound};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !empty) state_next = WAIT;
      WAIT: begin
        if (flush)         state_next = IDLE;
        else if (wait_end) state_next = HOLD;
      end
      HOLD: begin
        if (flush)          state_next = IDLE;
        else if (bat_ready) state_next = bat_last ? IDLE : WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prim_index <= '0;
      prim_bound <= '0;
      cnt        <= '0;
      bat_data   <= '0;
      bat_mask   <= '0;
      bat_last   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (accept && empty) || (flush && (state != IDLE));
      case (state)
        IDLE: if (accept && !empty) begin
          prim_index <= req_start;
          prim_bound <= bound_in;
          cnt        <= CNT_W'(LATENCY);
        end
        WAIT: if (!flush) begin
          cnt <= cnt - CNT_W'(1);
          if (wait_end) begin
            bat_data <= prim_data;
            bat_mask <= mask_c;
            bat_last <= last_c;
          end
        end
        HOLD: if (xfer && !bat_last) begin
          prim_index <= prim_index + IDX_W'(UNITS);
          cnt        <= CNT_W'(LATENCY);
        end
        default: ;
      endcase
    end
  end

  // Retire-on-last is combinational so done coincides with the final transfer while req_ready is still low.
  always_comb begin
    req_ready = (state == IDLE);
    bat_valid = (state == HOLD);
    done      = done_q || (xfer && bat_last);
  end

endmodule

// File: tb/tb_primitive_batch_sequencer.sv
// Directed bench for primitive_batch_sequencer: cycle-level reference model plus literal
// expectations on batch indexes, masks, bounds and done timing.
module tb_primitive_batch_sequencer;
  localparam int IDX_W = 16, UNITS = 2, PRIM_W = 256, LATENCY = 1;

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, flush, bat_valid, bat_ready, bat_last, done;
  logic [IDX_W-1:0] req_start, req_count, prim_index, prim_bound;
  logic [UNITS*PRIM_W-1:0] prim_data, bat_data;
  logic [UNITS-1:0] bat_mask;

  always #5 clk = ~clk;

  primitive_batch_sequencer #(.IDX_W(IDX_W), .UNITS(UNITS), .PRIM_W(PRIM_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_count(req_count), .flush(flush),
    .prim_index(prim_index), .prim_bound(prim_bound), .prim_data(prim_data),
    .bat_valid(bat_valid), .bat_ready(bat_ready), .bat_data(bat_data),
    .bat_mask(bat_mask), .bat_last(bat_last), .done(done)
  );

  // Primitive unit stand-in: each lane's record is a pattern derived from its own index.
  function automatic logic [UNITS*PRIM_W-1:0] pdata(input logic [15:0] idx);
    logic [UNITS*PRIM_W-1:0] r;
    logic [15:0] v;
    r = '0;
    for (int i = 0; i < UNITS; i++) begin
      v = (idx + 16'(i)) ^ 16'h3C5A;
      r[i*PRIM_W +: PRIM_W] = {16{v}};
    end
    return r;
  endfunction

  always_comb prim_data = pdata(prim_index);

  function automatic logic [16:0] end_of(input logic [15:0] s, input logic [15:0] c);
    logic [16:0] e;
    e = {1'b0, s} + {1'b0, c};
    return (e > 17'h07FFF) ? 17'h08000 : e;
  endfunction

  function automatic logic [1:0] mask_of(input logic [15:0] idx, input logic [16:0] e);
    logic [1:0] m;
    for (int i = 0; i < UNITS; i++) m[i] = ({1'b0, idx} + 17'(i)) < e;
    return m;
  endfunction

  function automatic logic last_of(input logic [15:0] idx, input logic [16:0] e);
    return ({1'b0, idx} + 17'(UNITS)) >= e;
  endfunction

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [UNITS*PRIM_W-1:0] got,
                         input logic [UNITS*PRIM_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: request range, current batch base and the cycle each batch becomes valid.
  int          cyc = 0;
  bit          started = 1'b0;
  bit          m_busy = 1'b0;
  logic [15:0] m_idx = '0;
  logic [16:0] m_end = '0;
  int          m_ready_cyc = 0;
  int          m_done_cyc = -1;

  always @(posedge clk) begin
    bit ev;
    ev = m_busy && (cyc >= m_ready_cyc);
    if (reset) begin
      started = 1'b1;
      m_busy = 1'b0;
      m_done_cyc = -1;
    end else if (started) begin
      if (!m_busy) begin
        if (req_valid && !flush) begin
          if (req_count == 0 || req_start[15]) m_done_cyc = cyc + 1;
          else begin
            m_busy = 1'b1;
            m_idx = req_start;
            m_end = end_of(req_start, req_count);
            m_ready_cyc = cyc + LATENCY + 1;
          end
        end
      end else if (flush) begin
        m_busy = 1'b0;
        m_done_cyc = cyc + 1;
      end else if (ev && bat_ready) begin
        if (last_of(m_idx, m_end)) m_busy = 1'b0;
        else begin
          m_idx = m_idx + 16'(UNITS);
          m_ready_cyc = cyc + LATENCY + 1;
        end
      end
    end
    cyc++;
  end

  int obs_idx[$], obs_mask[$], obs_last[$], obs_bound[$], obs_done[$], rise_q[$], done_cycles[$];
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    bit ev, el;
    if (started) begin
      ev = m_busy && (cyc >= m_ready_cyc);
      el = last_of(m_idx, m_end);
      check("req_ready", req_ready, !m_busy);
      check("bat_valid", bat_valid, ev);
      check("done", done, (cyc == m_done_cyc) || (ev && bat_ready && !flush && el));
      if (m_busy) begin
        check("prim_index", prim_index, m_idx);
        check("prim_bound", prim_bound, m_end[15:0]);
      end
      if (ev) begin
        check("bat_mask", bat_mask, mask_of(m_idx, m_end));
        check("bat_last", bat_last, el);
        check_w("bat_data", bat_data, pdata(m_idx));
      end
      if (bat_valid && bat_ready && !flush) begin
        obs_idx.push_back(int'(prim_index));
        obs_mask.push_back(int'(bat_mask));
        obs_last.push_back(int'(bat_last));
        obs_bound.push_back(int'(prim_bound));
        obs_done.push_back(int'(done));
      end
      if (bat_valid && !prev_v) rise_q.push_back(cyc);
      if (done) done_cycles.push_back(cyc);
      prev_v = bat_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int acc_cyc;

  task automatic request(input logic [15:0] s, input logic [15:0] c);
    req_start = s;
    req_count = c;
    req_valid = 1'b1;
    acc_cyc = cyc;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && !req_ready; n++) tick(1);
    check("wait_idle_timeout", req_ready, 1);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 50 && !bat_valid; n++) tick(1);
    check("wait_valid_timeout", bat_valid, 1);
  endtask

  task automatic clear_obs();
    obs_idx.delete(); obs_mask.delete(); obs_last.delete(); obs_bound.delete();
    obs_done.delete(); rise_q.delete(); done_cycles.delete();
  endtask

  task automatic check_batch(input string name, input int k, input int idx, input int mask,
                             input int last, input int bound);
    if (obs_idx.size() > k) begin
      check({name, "_idx"}, obs_idx[k], idx);
      check({name, "_mask"}, obs_mask[k], mask);
      check({name, "_last"}, obs_last[k], last);
      check({name, "_bound"}, obs_bound[k], bound);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_req_ready"}, req_ready, 1);
    check({name, "_bat_valid"}, bat_valid, 0);
    check({name, "_bat_last"}, bat_last, 0);
    check({name, "_bat_mask"}, bat_mask, 0);
    check({name, "_done"}, done, 0);
    check({name, "_prim_index"}, prim_index, 0);
    check({name, "_prim_bound"}, prim_bound, 0);
    check_w({name, "_bat_data"}, bat_data, '0);
  endtask

  initial begin
    int k;
    reset = 1'b1; req_valid = 1'b0; req_start = '0; req_count = '0; flush = 1'b0; bat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    tick(1);

    // Two full batches at 5 and 7, streaming
    clear_obs(); bat_ready = 1'b1;
    request(16'd5, 16'd4); k = acc_cyc;
    wait_idle();
    check("t1_batches", obs_idx.size(), 2);
    check_batch("t1_b0", 0, 5, 2'b11, 0, 9);
    check_batch("t1_b1", 1, 7, 2'b11, 1, 9);
    check("t1_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("t1_first_latency", rise_q[0] - k, 2);
      check("t1_second_latency", rise_q[1] - k, 4);
    end
    if (obs_done.size() == 2) begin
      check("t1_done_b0", obs_done[0], 0);
      check("t1_done_b1", obs_done[1], 1);
    end
    check("t1_done_count", done_cycles.size(), 1);

    // Partial last batch
    clear_obs();
    request(16'd8, 16'd3);
    wait_idle();
    check("t2_batches", obs_idx.size(), 2);
    check_batch("t2_b0", 0, 8, 2'b11, 0, 11);
    check_batch("t2_b1", 1, 10, 2'b01, 1, 11);

    // Empty requests: zero count, then null index
    clear_obs();
    request(16'd3, 16'd0);
    check("t3a_done", done, 1);
    check("t3a_req_ready", req_ready, 1);
    tick(1);
    check("t3a_done_clear", done, 0);
    request(16'h8000, 16'd5);
    check("t3b_done", done, 1);
    tick(3);
    check("t3_no_batches", rise_q.size(), 0);
    check("t3_done_count", done_cycles.size(), 2);

    // Backpressure in HOLD
    clear_obs(); bat_ready = 1'b0;
    request(16'd20, 16'd4);
    wait_valid();
    tick(5);
    check("t4_valid_held", bat_valid, 1);
    check("t4_mask_held", bat_mask, 2'b11);
    check("t4_last_held", bat_last, 0);
    check("t4_index_held", prim_index, 20);
    check_w("t4_data_held", bat_data, pdata(16'd20));
    check("t4_no_transfer", obs_idx.size(), 0);
    check("t4_single_rise", rise_q.size(), 1);
    bat_ready = 1'b1;
    wait_idle();
    check("t4_batches", obs_idx.size(), 2);
    check_batch("t4_b1", 1, 22, 2'b11, 1, 24);

    // Flush in HOLD with bat_ready high
    clear_obs(); bat_ready = 1'b0;
    request(16'd30, 16'd4);
    wait_valid();
    bat_ready = 1'b1; flush = 1'b1;
    tick(1);
    flush = 1'b0; bat_ready = 1'b0;
    check("t5_req_ready", req_ready, 1);
    check("t5_done", done, 1);
    check("t5_bat_valid", bat_valid, 0);
    check("t5_no_transfer", obs_idx.size(), 0);
    tick(1);
    check("t5_done_clear", done, 0);

    // Reset while waiting on the primitive unit
    clear_obs(); bat_ready = 1'b1;
    request(16'd40, 16'd6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_reset_vals("t6");
    request(16'd40, 16'd6);
    wait_idle();
    check("t6_batches", obs_idx.size(), 3);
    check_batch("t6_b0", 0, 40, 2'b11, 0, 46);
    check_batch("t6_b2", 2, 44, 2'b11, 1, 46);
    check("t6_done_count", done_cycles.size(), 1);

    // Saturated end index
    clear_obs();
    request(16'h7FF0, 16'h0040);
    wait_idle();
    check("t7a_batches", obs_idx.size(), 8);
    check_batch("t7a_b7", 7, 16'h7FFE, 2'b11, 1, 16'h8000);
    clear_obs();
    request(16'h7FFD, 16'hFFFF);
    wait_idle();
    check("t7b_batches", obs_idx.size(), 2);
    check_batch("t7b_b0", 0, 16'h7FFD, 2'b11, 0, 16'h8000);
    check_batch("t7b_b1", 1, 16'h7FFF, 2'b01, 1, 16'h8000);

    // Flush in IDLE blocks a simultaneous request
    clear_obs();
    req_start = 16'd50; req_count = 16'd4; req_valid = 1'b1; flush = 1'b1;
    tick(1);
    req_valid = 1'b0; flush = 1'b0;
    check("t8_req_ready", req_ready, 1);
    check("t8_done", done, 0);
    tick(3);
    check("t8_no_batches", rise_q.size(), 0);
    check("t8_no_done", done_cycles.size(), 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
